// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and control-vector layout for the nic8 ALU sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_LSR = 3'b100;
  localparam logic [2:0] OP_RRC = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_TST = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int CTRL_W         = 8;
  localparam int CTRL_SUB       = 7;
  localparam int CTRL_CIN       = 6;
  localparam int CTRL_SHIN      = 5;
  localparam int CTRL_USE_ADD   = 4;
  localparam int CTRL_USE_SHIFT = 3;
  localparam int CTRL_WRITE_A   = 2;
  localparam int CTRL_SET_C     = 1;
  localparam int CTRL_SET_S     = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode decode into the ALU control vector used by the sequencer FSM.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [2:0] op_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (op_i)
      OP_ADD: begin
        ctrl_o[CTRL_USE_ADD] = 1'b1;
        ctrl_o[CTRL_WRITE_A] = 1'b1;
        ctrl_o[CTRL_SET_C]   = 1'b1;
      end
      OP_ADC: begin
        ctrl_o[CTRL_CIN]     = 1'b1;
        ctrl_o[CTRL_USE_ADD] = 1'b1;
        ctrl_o[CTRL_WRITE_A] = 1'b1;
        ctrl_o[CTRL_SET_C]   = 1'b1;
      end
      OP_SUB: begin
        ctrl_o[CTRL_SUB]     = 1'b1;
        ctrl_o[CTRL_USE_ADD] = 1'b1;
        ctrl_o[CTRL_WRITE_A] = 1'b1;
        ctrl_o[CTRL_SET_C]   = 1'b1;
      end
      OP_SBC: begin
        ctrl_o[CTRL_SUB]     = 1'b1;
        ctrl_o[CTRL_CIN]     = 1'b1;
        ctrl_o[CTRL_USE_ADD] = 1'b1;
        ctrl_o[CTRL_WRITE_A] = 1'b1;
        ctrl_o[CTRL_SET_C]   = 1'b1;
      end
      OP_LSR: begin
        ctrl_o[CTRL_USE_SHIFT] = 1'b1;
        ctrl_o[CTRL_WRITE_A]   = 1'b1;
        ctrl_o[CTRL_SET_S]     = 1'b1;
      end
      OP_RRC: begin
        ctrl_o[CTRL_SHIN]      = 1'b1;
        ctrl_o[CTRL_USE_SHIFT] = 1'b1;
        ctrl_o[CTRL_WRITE_A]   = 1'b1;
        ctrl_o[CTRL_SET_S]     = 1'b1;
      end
      // Compare runs the subtractor only to refresh the carry flag
      OP_CMP: begin
        ctrl_o[CTRL_SUB]   = 1'b1;
        ctrl_o[CTRL_SET_C] = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU instruction through SETUP/EXEC/DONE, driving registered ALU strobes and A-load.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       aIsZero,
  output logic       doSubtract,
  output logic       doCarryIn,
  output logic       doShiftIn,
  output logic       assertBarE,
  output logic       assertBarS,
  output logic       triggerC,
  output logic       triggerS,
  output logic       loadBarA,
  output logic       busy,
  output logic       done,
  output logic       flagZ
);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  ctrl_t            ctrl;

  logic doSubtract_d, doCarryIn_d, doShiftIn_d;
  logic assertBarE_d, assertBarS_d, triggerC_d, triggerS_d, loadBarA_d;
  logic busy_d, done_d, flagZ_d;

  logic unused_instr;
  assign unused_instr = ^instr[4:0];

  alu_seq_decode u_decode (
    .op_i   (op_d),
    .ctrl_o (ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      doSubtract <= 1'b0;
      doCarryIn  <= 1'b0;
      doShiftIn  <= 1'b0;
      assertBarE <= 1'b1;
      assertBarS <= 1'b1;
      triggerC   <= 1'b0;
      triggerS   <= 1'b0;
      loadBarA   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      flagZ      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      doSubtract <= doSubtract_d;
      doCarryIn  <= doCarryIn_d;
      doShiftIn  <= doShiftIn_d;
      assertBarE <= assertBarE_d;
      assertBarS <= assertBarS_d;
      triggerC   <= triggerC_d;
      triggerS   <= triggerS_d;
      loadBarA   <= loadBarA_d;
      busy       <= busy_d;
      done       <= done_d;
      flagZ      <= flagZ_d;
    end
  end

  // Latched opcode only matters while busy, so it carries no reset
  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
          op_d    = instr[7:5];
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so every strobe leaves a flop
  always_comb begin
    doSubtract_d = 1'b0;
    doCarryIn_d  = 1'b0;
    doShiftIn_d  = 1'b0;
    assertBarE_d = 1'b1;
    assertBarS_d = 1'b1;
    triggerC_d   = 1'b0;
    triggerS_d   = 1'b0;
    loadBarA_d   = 1'b1;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    flagZ_d      = (state_q == DONE) ? aIsZero : flagZ;
    if (state_d != IDLE) begin
      doSubtract_d = ctrl[CTRL_SUB];
      doCarryIn_d  = ctrl[CTRL_CIN];
      doShiftIn_d  = ctrl[CTRL_SHIN];
    end
    if (state_d == EXEC) begin
      assertBarE_d = ~ctrl[CTRL_USE_ADD];
      assertBarS_d = ~ctrl[CTRL_USE_SHIFT];
      triggerC_d   = ctrl[CTRL_SET_C];
      triggerS_d   = ctrl[CTRL_SET_S];
      loadBarA_d   = ~ctrl[CTRL_WRITE_A];
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: two instances (SETUP_CYCLES 1 and 3) against a cycle-trace model.
module tb_alu_sequencer;

  typedef struct packed {
    logic [10:0] vec;
    logic        last;
    logic        znext;
  } rec_t;

  logic clk = 1'b0;
  logic reset, start, aIsZero, sel;
  logic [7:0] instr;
  logic start0, start1;

  logic doSub0, doCin0, doShin0, aBE0, aBS0, tC0, tS0, lBA0, busy0, done0, fZ0;
  logic doSub1, doCin1, doShin1, aBE1, aBS1, tC1, tS1, lBA1, busy1, done1, fZ1;
  logic [10:0] act0, act1;

  rec_t q0[$];
  rec_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt[2];
  logic idle_z[2];
  logic zmodel[2];
  logic mon_en = 1'b0;

  logic [7:0] A_m;
  logic       C_m, S_m;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign act0 = {doSub0, doCin0, doShin0, aBE0, aBS0, tC0, tS0, lBA0, busy0, done0, fZ0};
  assign act1 = {doSub1, doCin1, doShin1, aBE1, aBS1, tC1, tS1, lBA1, busy1, done1, fZ1};

  alu_sequencer #(.SETUP_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .instr(instr), .aIsZero(aIsZero),
    .doSubtract(doSub0), .doCarryIn(doCin0), .doShiftIn(doShin0),
    .assertBarE(aBE0), .assertBarS(aBS0), .triggerC(tC0), .triggerS(tS0),
    .loadBarA(lBA0), .busy(busy0), .done(done0), .flagZ(fZ0)
  );

  alu_sequencer #(.SETUP_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .instr(instr), .aIsZero(aIsZero),
    .doSubtract(doSub1), .doCarryIn(doCin1), .doShiftIn(doShin1),
    .assertBarE(aBE1), .assertBarS(aBS1), .triggerC(tC1), .triggerS(tS1),
    .loadBarA(lBA1), .busy(busy1), .done(done1), .flagZ(fZ1)
  );

  // Vector order: doSub doCin doShin aBarE aBarS trigC trigS loadBarA busy done flagZ
  function automatic logic [10:0] idle_vec(input logic z);
    return {3'b000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, z};
  endfunction

  // ph: 0 = setup cycle, 1 = exec cycle, 2 = done cycle
  function automatic logic [10:0] exp_vec(input logic [2:0] op, input int ph, input logic z);
    logic sub, cin, shin, addop, shop, wr, tc;
    sub   = (op == 3'd2) || (op == 3'd3) || (op == 3'd6);
    cin   = (op == 3'd1) || (op == 3'd3);
    shin  = (op == 3'd5);
    addop = (op <= 3'd3);
    shop  = (op == 3'd4) || (op == 3'd5);
    wr    = (op <= 3'd5);
    tc    = addop || (op == 3'd6);
    if (ph == 0) return {sub, cin, shin, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, z};
    if (ph == 1) return {sub, cin, shin, !addop, !shop, tc, shop, !wr, 1'b1, 1'b0, z};
    return {sub, cin, shin, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, z};
  endfunction

  task automatic check_dut(input int i, input logic [10:0] act);
    rec_t        r;
    logic        have;
    logic [10:0] exp;
    have = 1'b0;
    r    = '0;
    if (i == 0 && q0.size() > 0) begin r = q0.pop_front(); have = 1'b1; end
    if (i == 1 && q1.size() > 0) begin r = q1.pop_front(); have = 1'b1; end
    exp = have ? r.vec : idle_vec(idle_z[i]);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d cycle_outputs t=%0t: got %b, expected %b", i, $time, act, exp);
    end
    n_checks++;
    if (act[7] == 1'b0 && act[6] == 1'b0) begin
      n_fail++;
      $display("FAIL dut%0d both_asserts_low t=%0t: got aBarE=%b aBarS=%b, expected not both 0",
               i, $time, act[7], act[6]);
    end
    if (act[1]) done_cnt[i]++;
    if (have && r.last) idle_z[i] = r.znext;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_dut(0, act0);
      check_dut(1, act1);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input rec_t r);
    if (sel) q1.push_back(r);
    else q0.push_back(r);
  endtask

  task automatic alu_model(input logic [2:0] op, input logic [7:0] b, output logic z);
    logic [8:0] sum;
    logic       t;
    case (op)
      3'd0: begin sum = {1'b0, A_m} + {1'b0, b};                    A_m = sum[7:0]; C_m = sum[8]; end
      3'd1: begin sum = {1'b0, A_m} + {1'b0, b} + {8'd0, C_m};      A_m = sum[7:0]; C_m = sum[8]; end
      3'd2: begin sum = {1'b0, A_m} + {1'b0, ~b} + 9'd1;            A_m = sum[7:0]; C_m = sum[8]; end
      3'd3: begin sum = {1'b0, A_m} + {1'b0, ~b} + {8'd0, C_m};     A_m = sum[7:0]; C_m = sum[8]; end
      3'd4: begin S_m = A_m[0]; A_m = {1'b0, A_m[7:1]}; end
      3'd5: begin t = A_m[0]; A_m = {S_m, A_m[7:1]}; S_m = t; end
      3'd6: begin sum = {1'b0, A_m} + {1'b0, ~b} + 9'd1; C_m = sum[8]; end
      default: ;
    endcase
    z = (A_m == 8'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] b, input logic hold);
    int   s;
    logic z;
    rec_t r;
    s     = sel ? 3 : 1;
    instr = {op, 5'($urandom)};
    start = 1'b1;
    tick();
    alu_model(op, b, z);
    for (int k = 0; k < s; k++) begin
      r = '{vec: exp_vec(op, 0, zmodel[sel]), last: 1'b0, znext: 1'b0};
      push(r);
    end
    r = '{vec: exp_vec(op, 1, zmodel[sel]), last: 1'b0, znext: 1'b0};
    push(r);
    r = '{vec: exp_vec(op, 2, zmodel[sel]), last: 1'b1, znext: z};
    push(r);
    zmodel[sel] = z;
    aIsZero = !z;
    repeat (s) begin
      instr = 8'($urandom);
      if (!hold) start = 1'($urandom);
      tick();
    end
    instr = 8'($urandom);
    if (!hold) start = 1'($urandom);
    tick();
    aIsZero = z;
    tick();
    aIsZero = 1'($urandom);
    if (!hold) start = 1'b0;
  endtask

  task automatic held_three;
    int d0;
    d0 = done_cnt[sel];
    issue(3'($urandom), 8'($urandom), 1'b1);
    issue(3'($urandom), 8'($urandom), 1'b1);
    issue(3'($urandom), 8'($urandom), 1'b1);
    start = 1'b0;
    tick();
    tick();
    n_checks++;
    if (done_cnt[sel] - d0 != 3) begin
      n_fail++;
      $display("FAIL held_start_done_pulses sel=%0d: got %0d, expected 3", sel, done_cnt[sel] - d0);
    end
  endtask

  task automatic random_ops(input int n);
    logic h;
    for (int k = 0; k < n; k++) begin
      h = ($urandom % 3 == 0);
      issue(3'($urandom), 8'($urandom), h);
      if (!h) repeat ($urandom % 3) tick();
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr = 8'd0; aIsZero = 1'b0; sel = 1'b0;
    A_m = 8'd0; C_m = 1'b0; S_m = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    idle_z[0] = 1'b0; idle_z[1] = 1'b0; zmodel[0] = 1'b0; zmodel[1] = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();

    // SETUP_CYCLES = 1: 0xFF + 0x01 wraps to zero
    A_m = 8'hFF;
    issue(3'd0, 8'h01, 1'b0);
    tick();

    // Reset while the ADD is in EXEC
    mon_en = 1'b0;
    instr = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (act0 !== exp_vec(3'd0, 1, 1'b1)) begin
      n_fail++;
      $display("FAIL rst_pre_exec: got %b, expected %b", act0, exp_vec(3'd0, 1, 1'b1));
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (act0 !== idle_vec(1'b0)) begin
      n_fail++;
      $display("FAIL rst_mid_exec dut0: got %b, expected %b", act0, idle_vec(1'b0));
    end
    n_checks++;
    if (act1 !== idle_vec(1'b0)) begin
      n_fail++;
      $display("FAIL rst_mid_exec dut1: got %b, expected %b", act1, idle_vec(1'b0));
    end
    reset = 1'b0;
    zmodel[0] = 1'b0; zmodel[1] = 1'b0; idle_z[0] = 1'b0; idle_z[1] = 1'b0;
    A_m = 8'h5A;
    mon_en = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) begin
      issue(3'(k), 8'($urandom), 1'b0);
      tick();
    end
    held_three();
    random_ops(16);

    // SETUP_CYCLES = 3
    sel = 1'b1;
    tick();
    issue(3'd3, 8'($urandom), 1'b0);
    issue(3'd5, 8'($urandom), 1'b0);
    tick();
    issue(3'd6, 8'($urandom), 1'b0);
    tick();
    A_m = 8'h00;
    issue(3'd7, 8'($urandom), 1'b0);
    tick();
    A_m = 8'h01;
    issue(3'd7, 8'($urandom), 1'b0);
    tick();
    held_three();
    random_ops(20);

    repeat (6) tick();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
